// File: rtl/led7seg_anode_capture.sv
// Readback monitor for a multiplexed common-anode 7-segment bus.
// Rebuilds each digit's hex nibble once its pattern has been stable long enough.
module led7seg_anode_capture #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic                  la,
    input  logic                  lb,
    input  logic                  lc,
    input  logic                  ld,
    input  logic                  le,
    input  logic                  lf,
    input  logic                  lg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(STABLE + 1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   cand_idx, cand_idx_n;
    logic [6:0]      cand_pat, cand_pat_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DIGITS-1:0] seen, seen_n;

    logic [6:0]        pat;
    logic [DIGITS-1:0] sel;
    logic              one_low;
    logic [IW-1:0]     samp_idx;
    logic              is_sample;
    logic              is_ghost;
    logic              same;
    logic              commit;
    logic [DIGITS-1:0] commit_mask;
    logic [4:0]        gl;

    // Returns {legal, nibble} for an active-low pattern.
    function automatic logic [4:0] glyph(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h00;
        case (p)
            7'h01: r = {1'b1, 4'h0};
            7'h4F: r = {1'b1, 4'h1};
            7'h12: r = {1'b1, 4'h2};
            7'h06: r = {1'b1, 4'h3};
            7'h4C: r = {1'b1, 4'h4};
            7'h24: r = {1'b1, 4'h5};
            7'h20: r = {1'b1, 4'h6};
            7'h0F: r = {1'b1, 4'h7};
            7'h00: r = {1'b1, 4'h8};
            7'h04: r = {1'b1, 4'h9};
            7'h08: r = {1'b1, 4'hA};
            7'h60: r = {1'b1, 4'hB};
            7'h31: r = {1'b1, 4'hC};
            7'h42: r = {1'b1, 4'hD};
            7'h30: r = {1'b1, 4'hE};
            7'h38: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign pat = {la, lb, lc, ld, le, lf, lg};
    assign sel = ~an;
    assign one_low = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
    assign is_sample = sample_en && one_low;
    assign is_ghost = sample_en && !one_low;
    assign same = (samp_idx == cand_idx) && (pat == cand_pat);
    assign gl = glyph(pat);

    always_comb begin
        samp_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) samp_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cand_idx <= '0;
            cand_pat <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            cand_idx <= cand_idx_n;
            cand_pat <= cand_pat_n;
            cnt      <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cand_idx_n = cand_idx;
        cand_pat_n = cand_pat;
        cnt_n      = cnt;
        commit     = 1'b0;
        if (is_ghost) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (is_sample) begin
            // Any new candidate restarts the stability count at one.
            if (state == IDLE || !same) begin
                cand_idx_n = samp_idx;
                cand_pat_n = pat;
                cnt_n      = CW'(1);
                if (STABLE == 1) begin
                    commit  = 1'b1;
                    state_n = HOLD;
                end else begin
                    state_n = TRACK;
                end
            end else if (state == TRACK) begin
                cnt_n = cnt + CW'(1);
                if (cnt_n == CW'(STABLE)) begin
                    commit  = 1'b1;
                    state_n = HOLD;
                end
            end
        end
    end

    always_comb begin
        commit_mask = '0;
        for (int i = 0; i < DIGITS; i++) begin
            commit_mask[i] = commit && (samp_idx == IW'(i));
        end
        seen_n = ((&seen) ? '0 : seen) | commit_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value       <= '0;
            digit_err   <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (commit_mask[i]) begin
                    if (gl[4]) value[4*i +: 4] <= gl[3:0];
                    digit_err[i] <= !gl[4];
                end
            end
            seen        <= seen_n;
            frame_valid <= &seen_n;
        end
    end

endmodule

// File: tb/tb_led7seg_anode_capture.sv
// Directed bench for led7seg_anode_capture (DIGITS=4, STABLE=3).
// Expected outputs are queued with each step and checked one cycle later.
module tb_led7seg_anode_capture;

    logic        clk;
    logic        rst_n;
    logic        sample_en;
    logic        la, lb, lc, ld, le, lf, lg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  e;
        logic        f;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_fail;

    led7seg_anode_capture #(.DIGITS(4), .STABLE(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_en(sample_en),
        .la(la), .lb(lb), .lc(lc), .ld(ld),
        .le(le), .lf(lf), .lg(lg),
        .an(an),
        .value(value),
        .digit_err(digit_err),
        .frame_valid(frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    // Drive one cycle, then pop and check the expected post-edge outputs.
    task automatic step(input logic rst, input logic en, input logic [3:0] a,
                        input logic [6:0] p, input logic [15:0] ev,
                        input logic [3:0] ee, input logic ef, input string tag);
        exp_t x;
        exp_q.push_back('{v: ev, e: ee, f: ef});
        rst_n     = rst;
        sample_en = en;
        an        = a;
        {la, lb, lc, ld, le, lf, lg} = p;
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        n_cmp++;
        assert (value === x.v) else begin
            n_fail++;
            $error("FAIL %s value: observed %h expected %h", tag, value, x.v);
        end
        n_cmp++;
        assert (digit_err === x.e) else begin
            n_fail++;
            $error("FAIL %s digit_err: observed %b expected %b", tag, digit_err, x.e);
        end
        n_cmp++;
        assert (frame_valid === x.f) else begin
            n_fail++;
            $error("FAIL %s frame_valid: observed %b expected %b", tag, frame_valid, x.f);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        sample_en = 1'b0;
        an = 4'hF;
        {la, lb, lc, ld, le, lf, lg} = 7'h7F;
        @(negedge clk);

        step(0, 1, 4'b1110, 7'h12, 16'h0000, 4'h0, 0, "reset0");
        step(0, 1, 4'b1110, 7'h12, 16'h0000, 4'h0, 0, "reset1");

        step(1, 1, 4'b1110, 7'h12, 16'h0000, 4'h0, 0, "glitch_a");
        step(1, 1, 4'b1110, 7'h12, 16'h0000, 4'h0, 0, "glitch_b");
        step(1, 1, 4'b1110, 7'h06, 16'h0000, 4'h0, 0, "glitch_c");
        step(1, 1, 4'b1110, 7'h06, 16'h0000, 4'h0, 0, "glitch_d");
        step(1, 1, 4'b1110, 7'h06, 16'h0003, 4'h0, 0, "glitch_commit");

        step(1, 1, 4'b1110, 7'h12, 16'h0003, 4'h0, 0, "stab_1");
        step(1, 1, 4'b1110, 7'h12, 16'h0003, 4'h0, 0, "stab_2");
        step(1, 1, 4'b1110, 7'h12, 16'h0002, 4'h0, 0, "stab_3");
        step(1, 1, 4'b1110, 7'h12, 16'h0002, 4'h0, 0, "stab_hold");

        step(0, 0, 4'b1110, 7'h12, 16'h0000, 4'h0, 0, "reset2");
        for (int k = 0; k < 3; k++)
            step(1, 1, 4'b0111, 7'h4F, (k == 2) ? 16'h1000 : 16'h0000, 4'h0, 0, "frame_d3");
        for (int k = 0; k < 3; k++)
            step(1, 1, 4'b1011, 7'h12, (k == 2) ? 16'h1200 : 16'h1000, 4'h0, 0, "frame_d2");
        step(1, 0, 4'b1100, 7'h7F, 16'h1200, 4'h0, 0, "frame_gap");
        for (int k = 0; k < 3; k++)
            step(1, 1, 4'b1101, 7'h06, (k == 2) ? 16'h1230 : 16'h1200, 4'h0, 0, "frame_d1");
        for (int k = 0; k < 3; k++)
            step(1, 1, 4'b1110, 7'h4C, (k == 2) ? 16'h1234 : 16'h1230, 4'h0, k == 2, "frame_d0");
        step(1, 1, 4'b1110, 7'h4C, 16'h1234, 4'h0, 0, "frame_after");

        for (int k = 0; k < 3; k++)
            step(1, 1, 4'b1101, 7'h7F, 16'h1234, (k == 2) ? 4'b0010 : 4'b0000, 0, "err_d1");

        step(1, 1, 4'b1011, 7'h31, 16'h1234, 4'b0010, 0, "ghost_a");
        step(1, 1, 4'b1011, 7'h31, 16'h1234, 4'b0010, 0, "ghost_b");
        step(1, 1, 4'b1100, 7'h31, 16'h1234, 4'b0010, 0, "ghost_hit");
        step(1, 1, 4'b1011, 7'h31, 16'h1234, 4'b0010, 0, "ghost_c");
        step(1, 0, 4'b1100, 7'h31, 16'h1234, 4'b0010, 0, "ghost_gap");
        step(1, 1, 4'b1011, 7'h31, 16'h1234, 4'b0010, 0, "ghost_d");
        step(1, 1, 4'b1011, 7'h31, 16'h1C34, 4'b0010, 0, "ghost_commit");

        for (int k = 0; k < 3; k++)
            step(1, 1, 4'b1101, 7'h06, 16'h1C34, (k == 2) ? 4'b0000 : 4'b0010, 0, "err_clear");

        step(0, 0, 4'b1111, 7'h7F, 16'h0000, 4'h0, 0, "reset3");
        for (int k = 0; k < 3; k++)
            step(1, 1, 4'b1110, 7'h00, (k == 2) ? 16'h0008 : 16'h0000, 4'h0, 0, "mid_d0");
        for (int k = 0; k < 3; k++)
            step(1, 1, 4'b1101, 7'h04, (k == 2) ? 16'h0098 : 16'h0008, 4'h0, 0, "mid_d1");
        step(1, 1, 4'b1011, 7'h08, 16'h0098, 4'h0, 0, "mid_d2a");
        step(1, 1, 4'b1011, 7'h08, 16'h0098, 4'h0, 0, "mid_d2b");
        step(1, 1, 4'b1011, 7'h08, 16'h0A98, 4'h0, 0, "mid_d2c");
        step(0, 1, 4'b1011, 7'h08, 16'h0000, 4'h0, 0, "mid_reset");
        for (int k = 0; k < 3; k++)
            step(1, 1, 4'b0111, 7'h38, (k == 2) ? 16'hF000 : 16'h0000, 4'h0, 0, "mid_d3");
        step(1, 1, 4'b0111, 7'h38, 16'hF000, 4'h0, 0, "mid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
